// File: rtl/aes_ctr_framer_if.sv
// aes_ctr_framer_if: descriptor, plaintext-in and frame-out buses of aes_ctr_framer (Cfg_chain only with AES_FRAMER_IV_CHAIN_EN)
interface aes_ctr_framer_if #(
  parameter int BLOCK_SIZE = 128,
  parameter int KEY_LENGTH = 256,
  parameter int COUNT_WIDTH = 32
);
  logic Cfg_valid;
  logic Cfg_ready;
  logic [KEY_LENGTH-1:0] Cfg_key;
  logic [BLOCK_SIZE-1:0] Cfg_counter;
`ifdef AES_FRAMER_IV_CHAIN_EN
  logic Cfg_chain;
`endif
  logic S_axis_tvalid;
  logic S_axis_tready;
  logic [BLOCK_SIZE-1:0] S_axis_tdata;
  logic [BLOCK_SIZE/8-1:0] S_axis_tkeep;
  logic S_axis_tlast;
  logic M_axis_tvalid;
  logic M_axis_tready;
  logic [BLOCK_SIZE-1:0] M_axis_tdata;
  logic [BLOCK_SIZE/8-1:0] M_axis_tkeep;
  logic M_axis_tlast;
  logic M_axis_tuser;
  logic Busy;
  logic [COUNT_WIDTH-1:0] Frame_beats;
  modport slave (
`ifdef AES_FRAMER_IV_CHAIN_EN
    input Cfg_chain,
`endif
    input Cfg_valid, Cfg_key, Cfg_counter, S_axis_tvalid, S_axis_tdata, S_axis_tkeep, S_axis_tlast, M_axis_tready,
    output Cfg_ready, S_axis_tready, M_axis_tvalid, M_axis_tdata, M_axis_tkeep, M_axis_tlast, M_axis_tuser, Busy, Frame_beats
  );
  modport master (
`ifdef AES_FRAMER_IV_CHAIN_EN
    output Cfg_chain,
`endif
    output Cfg_valid, Cfg_key, Cfg_counter, S_axis_tvalid, S_axis_tdata, S_axis_tkeep, S_axis_tlast, M_axis_tready,
    input Cfg_ready, S_axis_tready, M_axis_tvalid, M_axis_tdata, M_axis_tkeep, M_axis_tlast, M_axis_tuser, Busy, Frame_beats
  );
endinterface

// File: rtl/aes_ctr_framer.sv
// aes_ctr_framer: builds key-lo, key-hi, counter header then passes payload through to the AES-CTR core; counter chaining under AES_FRAMER_IV_CHAIN_EN
module aes_ctr_framer #(
  parameter int BLOCK_SIZE = 128,
  parameter int KEY_LENGTH = 256,
  parameter int COUNT_WIDTH = 32
) (
  input logic Clk,
  input logic Rst,
  aes_ctr_framer_if.slave b
);
  localparam int KEEP_W = BLOCK_SIZE / 8;
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_KEY_HI  = 4'b0010,
    ST_COUNTER = 4'b0100,
    ST_PAYLOAD = 4'b1000
  } state_t;
  state_t state, state_n;
  logic [KEY_LENGTH-1:0] key_reg;
  logic [BLOCK_SIZE-1:0] ctr_reg, ctr_next, d_data;
  logic [KEEP_W-1:0] d_keep;
  logic slot_free, cfg_fire, s_fire, load, d_last, d_user;
  assign slot_free = ~b.M_axis_tvalid | b.M_axis_tready;
  assign cfg_fire = b.Cfg_valid & slot_free & (state == ST_IDLE);
  assign s_fire = b.S_axis_tvalid & slot_free & (state == ST_PAYLOAD);
  assign b.Busy = state != ST_IDLE;
`ifdef AES_FRAMER_IV_CHAIN_EN
  function automatic logic [BLOCK_SIZE-1:0] bswap(input logic [BLOCK_SIZE-1:0] x);
    for (int i = 0; i < KEEP_W; i++) bswap[8*i +: 8] = x[BLOCK_SIZE-8-8*i +: 8];
  endfunction
  assign ctr_next = b.Cfg_chain ? bswap(bswap(ctr_reg) + BLOCK_SIZE'(b.Frame_beats)) : b.Cfg_counter;
`else
  assign ctr_next = b.Cfg_counter;
`endif
  // next state, handshake readies and the beat offered to the output register
  always_comb begin
    state_n = state;
    load = 1'b0;
    d_data = '0;
    d_keep = '1;
    d_last = 1'b0;
    d_user = 1'b1;
    b.Cfg_ready = 1'b0;
    b.S_axis_tready = 1'b0;
    case (state)
      ST_IDLE: begin
        b.Cfg_ready = slot_free;
        load = cfg_fire;
        d_data = b.Cfg_key[BLOCK_SIZE-1:0];
        state_n = cfg_fire ? ST_KEY_HI : ST_IDLE;
      end
      ST_KEY_HI: begin
        load = slot_free;
        d_data = key_reg[KEY_LENGTH-1:BLOCK_SIZE];
        state_n = slot_free ? ST_COUNTER : ST_KEY_HI;
      end
      ST_COUNTER: begin
        load = slot_free;
        d_data = ctr_reg;
        state_n = slot_free ? ST_PAYLOAD : ST_COUNTER;
      end
      ST_PAYLOAD: begin
        b.S_axis_tready = slot_free;
        load = s_fire;
        d_data = b.S_axis_tdata;
        d_keep = b.S_axis_tkeep;
        d_last = b.S_axis_tlast;
        d_user = 1'b0;
        state_n = s_fire & b.S_axis_tlast ? ST_IDLE : ST_PAYLOAD;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  // state, latched descriptor and payload beat counter
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
      key_reg <= '0;
      ctr_reg <= '0;
      b.Frame_beats <= '0;
    end else begin
      state <= state_n;
      if (cfg_fire) begin
        key_reg <= b.Cfg_key;
        ctr_reg <= ctr_next;
        b.Frame_beats <= '0;
      end
      if (s_fire) b.Frame_beats <= b.Frame_beats + COUNT_WIDTH'(1);
    end
  end
  // single output register; it only moves when the slot is free so stalled beats hold
  always_ff @(posedge Clk) begin
    if (Rst) begin
      b.M_axis_tvalid <= 1'b0;
      b.M_axis_tdata <= '0;
      b.M_axis_tkeep <= '0;
      b.M_axis_tlast <= 1'b0;
      b.M_axis_tuser <= 1'b0;
    end else if (slot_free) begin
      b.M_axis_tvalid <= load;
      if (load) begin
        b.M_axis_tdata <= d_data;
        b.M_axis_tkeep <= d_keep;
        b.M_axis_tlast <= d_last;
        b.M_axis_tuser <= d_user;
      end
    end
  end
endmodule

// File: tb/tb_aes_ctr_framer.sv
// tb_aes_ctr_framer: directed frames checked against an expected-beat queue plus literal header values
module tb_aes_ctr_framer;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;
  aes_ctr_framer_if bus ();
  aes_ctr_framer dut (.Clk(Clk), .Rst(Rst), .b(bus));
  logic [145:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int m_count = 0;
  logic [31:0] m_beats = '0;
  logic bp_en = 1'b0;
`ifdef AES_FRAMER_IV_CHAIN_EN
  logic [127:0] m_ctr = '0;
  logic cfg_chain_val = 1'b0;
  function automatic logic [127:0] bs(input logic [127:0] x);
    logic [127:0] r;
    r = {<<8{x}};
    return r;
  endfunction
`endif
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask
  // every meaningful output cycle: the beat on the bus must be the oldest outstanding expected beat
  always @(negedge Clk) begin
    if (!Rst) begin
      chk("frame_beats", bus.Frame_beats, m_beats);
      if (bus.M_axis_tvalid) begin
        if (exp_q.size() == 0) bound_fail("m_unexpected_beat");
        else begin
          chk("m_beat", {bus.M_axis_tdata, bus.M_axis_tkeep, bus.M_axis_tlast, bus.M_axis_tuser}, exp_q[0]);
          if (bus.M_axis_tready) begin
            void'(exp_q.pop_front());
            m_count++;
          end
        end
      end
    end
  end
  always @(posedge Clk) if (bp_en) #1 bus.M_axis_tready = ~bus.M_axis_tready;
  task automatic cfg_send(input logic [255:0] key, input logic [127:0] ctr);
    logic [127:0] c;
    bit ok;
    ok = 0;
    bus.Cfg_valid = 1'b1;
    bus.Cfg_key = key;
    bus.Cfg_counter = ctr;
`ifdef AES_FRAMER_IV_CHAIN_EN
    bus.Cfg_chain = cfg_chain_val;
`endif
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clk);
      ok = bus.Cfg_ready;
      @(posedge Clk);
      #1;
    end
    bus.Cfg_valid = 1'b0;
    if (!ok) bound_fail("cfg_handshake");
    else begin
      c = ctr;
`ifdef AES_FRAMER_IV_CHAIN_EN
      if (cfg_chain_val) c = bs(bs(m_ctr) + {96'b0, m_beats});
      m_ctr = c;
`endif
      m_beats = '0;
      exp_q.push_back({key[127:0], 16'hFFFF, 1'b0, 1'b1});
      exp_q.push_back({key[255:128], 16'hFFFF, 1'b0, 1'b1});
      exp_q.push_back({c, 16'hFFFF, 1'b0, 1'b1});
    end
  endtask
  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
    bit ok;
    ok = 0;
    bus.S_axis_tvalid = 1'b1;
    bus.S_axis_tdata = d;
    bus.S_axis_tkeep = k;
    bus.S_axis_tlast = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clk);
      ok = bus.S_axis_tready;
      @(posedge Clk);
      #1;
    end
    if (!ok) bound_fail("s_handshake");
    else begin
      exp_q.push_back({d, k, l, 1'b0});
      m_beats++;
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge Clk);
      #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1, "timeout");
  end
  initial begin
    bus.Cfg_valid = 1'b0;
    bus.Cfg_key = '0;
    bus.Cfg_counter = '0;
`ifdef AES_FRAMER_IV_CHAIN_EN
    bus.Cfg_chain = 1'b0;
`endif
    bus.S_axis_tvalid = 1'b0;
    bus.S_axis_tdata = '0;
    bus.S_axis_tkeep = '0;
    bus.S_axis_tlast = 1'b0;
    bus.M_axis_tready = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset_outputs", {bus.M_axis_tvalid, bus.M_axis_tdata, bus.M_axis_tkeep, bus.M_axis_tlast, bus.M_axis_tuser}, 0);
    chk("reset_status", {bus.Busy, bus.Frame_beats, bus.S_axis_tready, bus.Cfg_ready}, {1'b0, 32'd0, 1'b0, 1'b1});
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    bus.M_axis_tready = 1'b1;
    // single frame with literal header values
    m_count = 0;
    cfg_send(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    chk("t1_key_lo", {bus.M_axis_tvalid, bus.M_axis_tuser, bus.M_axis_tkeep, bus.M_axis_tdata}, {2'b11, 16'hFFFF, 128'h101112131415161718191a1b1c1d1e1f});
    @(posedge Clk);
    #1;
    chk("t1_key_hi", bus.M_axis_tdata, 128'h000102030405060708090a0b0c0d0e0f);
    @(posedge Clk);
    #1;
    chk("t1_counter", {bus.M_axis_tuser, bus.M_axis_tdata}, {1'b1, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff});
    send_beat(128'hAAAA0000_11112222_33334444_55556666, 16'hFFFF, 1'b0);
    chk("t1_pay0", {bus.M_axis_tuser, bus.M_axis_tlast, bus.M_axis_tdata}, {2'b00, 128'hAAAA0000_11112222_33334444_55556666});
    send_beat(128'hBBBB0000_77778888_9999AAAA_BBBBCCCC, 16'hFFFF, 1'b1);
    chk("t1_pay1_last", {bus.M_axis_tuser, bus.M_axis_tlast}, 2'b01);
    bus.S_axis_tvalid = 1'b0;
    drain();
    chk("t1_beat_count", m_count, 5);
    chk("t1_frame_beats", {bus.Busy, bus.Frame_beats}, {1'b0, 32'd2});
    // backpressure with alternating ready
    m_count = 0;
    bp_en = 1'b1;
    cfg_send({128'h2222, 128'h1111}, 128'h3333);
    send_beat(128'h10, 16'hFFFF, 1'b0);
    send_beat(128'h20, 16'h0F0F, 1'b0);
    send_beat(128'h30, 16'hFFFF, 1'b0);
    send_beat(128'h40, 16'h00FF, 1'b1);
    bus.S_axis_tvalid = 1'b0;
    drain();
    bp_en = 1'b0;
    #3;
    bus.M_axis_tready = 1'b1;
    chk("t2_beat_count", m_count, 7);
    @(posedge Clk);
    #1;
    // back-to-back frames: second descriptor accepted while the last beat leaves
    cfg_send({128'h4444, 128'h5555}, 128'h6666);
    send_beat(128'h50, 16'hFFFF, 1'b0);
    chk("t3_cfg_ready_payload", bus.Cfg_ready, 1'b0);
    send_beat(128'h60, 16'hFFFF, 1'b1);
    bus.S_axis_tvalid = 1'b0;
    chk("t3_last_slot", {bus.M_axis_tvalid, bus.M_axis_tlast, bus.Cfg_ready}, 3'b111);
    cfg_send({128'h7777, 128'h8888}, 128'h9999);
    chk("t3_no_gap_key_lo", {bus.M_axis_tvalid, bus.M_axis_tuser, bus.M_axis_tdata}, {2'b11, 128'h8888});
    send_beat(128'h70, 16'h0001, 1'b1);
    bus.S_axis_tvalid = 1'b0;
    drain();
    // reset mid-frame, with a payload beat offered during reset
    cfg_send({128'hAAAA, 128'hBBBB}, 128'hCCCC);
    drain();
    Rst = 1'b1;
    bus.S_axis_tvalid = 1'b1;
    bus.S_axis_tdata = 128'hDEAD;
    bus.S_axis_tlast = 1'b0;
    exp_q.delete();
    m_beats = '0;
`ifdef AES_FRAMER_IV_CHAIN_EN
    m_ctr = '0;
`endif
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    bus.S_axis_tvalid = 1'b0;
    @(negedge Clk);
    chk("t4_after_reset", {bus.M_axis_tvalid, bus.Busy, bus.S_axis_tready}, 3'b000);
    @(posedge Clk);
    #1;
    cfg_send({128'hD1D1, 128'hE1E1}, 128'hF1F1);
    chk("t4_clean_key_lo", {bus.M_axis_tuser, bus.M_axis_tdata}, {1'b1, 128'hE1E1});
    send_beat(128'h80, 16'hFFFF, 1'b1);
    bus.S_axis_tvalid = 1'b0;
    drain();
`ifdef AES_FRAMER_IV_CHAIN_EN
    // chained counter: FE in the top byte plus 3 beats carries into the next byte
    cfg_send({128'h1, 128'h2}, 128'hFE00_0000_0000_0000_0000_0000_0000_0000);
    send_beat(128'h1, 16'hFFFF, 1'b0);
    send_beat(128'h2, 16'hFFFF, 1'b0);
    send_beat(128'h3, 16'hFFFF, 1'b1);
    bus.S_axis_tvalid = 1'b0;
    drain();
    cfg_chain_val = 1'b1;
    cfg_send({128'h3, 128'h4}, 128'h1234_5678);
    cfg_chain_val = 1'b0;
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    chk("t5_chain_counter", bus.M_axis_tdata, 128'h0101_0000_0000_0000_0000_0000_0000_0000);
    send_beat(128'h4, 16'hFFFF, 1'b1);
    bus.S_axis_tvalid = 1'b0;
    drain();
`endif
    // payload gap of five cycles, including an all-zero tkeep beat
    cfg_send({128'h1212, 128'h3434}, 128'h5656);
    send_beat(128'h90, 16'hFFFF, 1'b0);
    send_beat(128'hA0, 16'h0000, 1'b0);
    bus.S_axis_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (i > 0) chk("t6_gap", {bus.M_axis_tvalid, bus.Busy, bus.S_axis_tready}, 3'b011);
      @(posedge Clk);
      #1;
    end
    send_beat(128'hB0, 16'hFFFF, 1'b0);
    send_beat(128'hC0, 16'h7FFF, 1'b1);
    bus.S_axis_tvalid = 1'b0;
    drain();
    chk("t6_frame_beats", bus.Frame_beats, 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
